axis_sm_bk_sink: RTL and testbench
==================================

// Module: axis_sm_bk_sink
// PURPOSE
// - AXI-Stream slave sink for the SM stream: accepts beats on axis_sm_*, buffers them in a FIFO and replays each beat to the backdoor consumer as a start/done transaction on bk_sm_*.
// - Sits directly downstream of the SM stream source in the axilite_axis testbench; this is the consumer of axis_sm_* and the producer of bk_sm_*.
// PARAMETERS
// - DEPTH  4  FIFO entries, power of 2, >=2
// PORTS
// - axi_sm_aclk      in   1   clock
// - axi_sm_aresetn   in   1   reset, asynchronous, active-low
// - axis_sm_tvalid   in   1   stream beat valid
// - axis_sm_tdata    in   32  stream data
// - axis_sm_tstrb    in   4   byte strobes
// - axis_sm_tkeep    in   4   byte keeps
// - axis_sm_tlast    in   1   last beat of frame
// - axis_sm_tuser    in   2   sideband
// - axis_sm_tready   out  1   beat accepted when tvalid&tready
// - bk_sm_start      out  1   one-cycle pulse, new backdoor transaction
// - bk_sm_data       out  32  beat data, held start..done
// - bk_sm_tstrb      out  4   beat tstrb, held start..done
// - bk_sm_tkeep      out  4   beat tkeep, held start..done
// - bk_sm_user       out  2   beat tuser, held start..done
// - bk_sm_last       out  1   beat tlast, held start..done
// - bk_sm_nordy      in   1   consumer not ready; blocks issuing new start
// - bk_sm_done       in   1   consumer finished current transaction (pulse)
// - fifo_level       out  $clog2(DEPTH)+1  entries held
// - beat_count       out  32  completed backdoor beats, wraps 0xFFFFFFFF->0
// - frame_count      out  16  tlast beats retired (delivered or dropped), wraps
// - err_spurious     out  1   sticky: bk_sm_done seen while no transaction open
// BEHAVIOUR
// - Reset: all outputs 0 (axis_sm_tready=0, bk_sm_start=0, bk_sm_* data=0, counters=0, err=0); FIFO emptied; FSM->IDLE. Mid-operation reset aborts the open transaction, and the beat is lost.
// - FIFO entry = {tuser,tlast,tkeep,tstrb,tdata} (43b). Push on tvalid&tready; pop on retire.
// - axis_sm_tready is registered: tready <= (level_next < DEPTH). First cycle after reset release it is 0, then 1. Simultaneous push+pop when full: the pop happens, and tready rises the next cycle.
// - tready never depends combinationally on tvalid. Input fields are sampled only on the accepting edge.
// - Null beat: head with tkeep==4'b0000 is retired in IDLE in 1 cycle with no bk_sm_start. frame_count++ if its tlast=1, and beat_count is not changed.
// - FSM IDLE: head non-null & FIFO non-empty & !bk_sm_nordy -> register head onto bk_sm_* fields, bk_sm_start=1 for exactly 1 cycle, go WAIT.
// - FSM WAIT: bk_sm_nordy is ignored. On bk_sm_done: pop head, beat_count++, frame_count++ if bk_sm_last, go IDLE.
// - bk_sm_done in the same cycle as bk_sm_start is ignored, and so is done in the start cycle; done counts only from the cycle after start.
// - bk_sm_* fields keep their last value after done until the next start.
// - Throughput: a new start can be issued no sooner than 1 cycle after done (min 3 cycles/beat incl. done latency 1).
// - bk_sm_done in IDLE: err_spurious<=1 (sticky until reset), with no other effect.
// - Latency: beat accepted at edge N, FIFO empty, nordy=0 -> bk_sm_start high in cycle N+1.
// - Order is strictly preserved; no beat is duplicated or dropped except null beats and on reset.
// TESTING
// - Single beat tdata=0xA5A5_0001 tkeep=F tlast=1, done 2 cycles after start -> one start pulse, bk_sm_data=0xA5A50001, bk_sm_last=1, beat_count=1, frame_count=1.
// - 6 beats back-to-back with done withheld, DEPTH=4 -> tready drops after the 4th accept, fifo_level=4; give done 6 times -> data 0..5 in order, beat_count=6.
// - nordy=1 with 2 beats queued -> no start, level=2; drop nordy -> start next cycle; set nordy=1 during WAIT -> done still retires the beat.
// - Beat tkeep=0 tlast=1 between two data beats -> only 2 starts, beat_count=2, frame_count=1.
// - done pulse while IDLE -> err_spurious=1 and it stays 1; beat_count unchanged.
// - Assert aresetn low while in WAIT with 3 queued -> all outputs 0 immediately, level=0; after release tready=1 and a new beat is delivered normally.

Source files
------------

// File: rtl/axis_sm_bk_sink.sv
// AXI-Stream SM sink: buffers accepted beats in a FIFO and replays each as a start/done backdoor transaction.
// Latency: beat accepted at edge N into an empty FIFO -> bk_sm_start high in the cycle after edge N+1.
// Backpressure: registered tready drops when the FIFO is full; bk_sm_nordy holds off new starts in IDLE.
//
// Ports:
//   axi_sm_aclk / axi_sm_aresetn     clock, async active-low reset
//   axis_sm_t*                       AXI-Stream slave (valid/ready)
//   bk_sm_start/done/nordy           backdoor handshake; bk_sm_* fields held from start until next start
//   fifo_level                       entries currently buffered
//   beat_count/frame_count           delivered beats / retired tlast beats (both wrap)
//   err_spurious                     sticky flag: done received with no transaction open
module axis_sm_bk_sink #(
  parameter int DEPTH = 4
) (
  input  logic                       axi_sm_aclk,
  input  logic                       axi_sm_aresetn,
  input  logic                       axis_sm_tvalid,
  input  logic [31:0]                axis_sm_tdata,
  input  logic [3:0]                 axis_sm_tstrb,
  input  logic [3:0]                 axis_sm_tkeep,
  input  logic                       axis_sm_tlast,
  input  logic [1:0]                 axis_sm_tuser,
  output logic                       axis_sm_tready,
  output logic                       bk_sm_start,
  output logic [31:0]                bk_sm_data,
  output logic [3:0]                 bk_sm_tstrb,
  output logic [3:0]                 bk_sm_tkeep,
  output logic [1:0]                 bk_sm_user,
  output logic                       bk_sm_last,
  input  logic                       bk_sm_nordy,
  input  logic                       bk_sm_done,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic [31:0]                beat_count,
  output logic [15:0]                frame_count,
  output logic                       err_spurious
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = 43;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;

  state_t        state_q, state_d;

  // FIFO storage: entry = {tuser, tlast, tkeep, tstrb, tdata}
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [LW-1:0] level_q, level_next;

  logic          push, pop;
  logic          fifo_empty;
  logic [EW-1:0] head;
  logic [31:0]   head_data;
  logic [3:0]    head_strb, head_keep;
  logic          head_last;
  logic [1:0]    head_user;
  logic          head_null;

  logic          issue, null_pop, done_pop, spurious;

  assign head       = mem[rd_ptr];
  assign head_data  = head[31:0];
  assign head_strb  = head[35:32];
  assign head_keep  = head[39:36];
  assign head_last  = head[40];
  assign head_user  = head[42:41];
  assign head_null  = (head_keep == 4'b0000);
  assign fifo_empty = (level_q == '0);

  assign push       = axis_sm_tvalid & axis_sm_tready;
  assign pop        = null_pop | done_pop;
  assign level_next = level_q + LW'(push) - LW'(pop);
  assign fifo_level = level_q;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge axi_sm_aclk or negedge axi_sm_aresetn) begin
    if (!axi_sm_aresetn) state_q <= S_IDLE;
    else                 state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (issue)    state_d = S_START;
      // Done during the start cycle is deliberately ignored.
      S_START:               state_d = S_WAIT;
      S_WAIT:  if (done_pop) state_d = S_IDLE;
      default:               state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs / strobes ----------------
  always_comb begin
    bk_sm_start = 1'b0;
    issue       = 1'b0;
    null_pop    = 1'b0;
    done_pop    = 1'b0;
    spurious    = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Null beats drain regardless of nordy; they never reach the consumer.
        null_pop = !fifo_empty && head_null;
        issue    = !fifo_empty && !head_null && !bk_sm_nordy;
        spurious = bk_sm_done;
      end
      S_START: bk_sm_start = 1'b1;
      S_WAIT:  done_pop    = bk_sm_done;
      default: ;
    endcase
  end

  // ---------------- FIFO ----------------
  always_ff @(posedge axi_sm_aclk) begin
    if (push) mem[wr_ptr] <= {axis_sm_tuser, axis_sm_tlast, axis_sm_tkeep, axis_sm_tstrb, axis_sm_tdata};
  end

  always_ff @(posedge axi_sm_aclk or negedge axi_sm_aresetn) begin
    if (!axi_sm_aresetn) begin
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      level_q        <= '0;
      axis_sm_tready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level_q        <= level_next;
      // Registered ready: looks at the post-edge level so a pop while full reopens next cycle.
      axis_sm_tready <= (level_next < DEPTH_L);
    end
  end

  // ---------------- Backdoor fields, counters, error ----------------
  always_ff @(posedge axi_sm_aclk or negedge axi_sm_aresetn) begin
    if (!axi_sm_aresetn) begin
      bk_sm_data   <= '0;
      bk_sm_tstrb  <= '0;
      bk_sm_tkeep  <= '0;
      bk_sm_user   <= '0;
      bk_sm_last   <= 1'b0;
      beat_count   <= '0;
      frame_count  <= '0;
      err_spurious <= 1'b0;
    end else begin
      if (issue) begin
        bk_sm_data  <= head_data;
        bk_sm_tstrb <= head_strb;
        bk_sm_tkeep <= head_keep;
        bk_sm_user  <= head_user;
        bk_sm_last  <= head_last;
      end
      if (done_pop) beat_count <= beat_count + 32'd1;
      if ((done_pop && bk_sm_last) || (null_pop && head_last))
        frame_count <= frame_count + 16'd1;
      if (spurious) err_spurious <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axis_sm_bk_sink.sv
module tb_axis_sm_bk_sink;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tvalid;
  logic [31:0] tdata;
  logic [3:0]  tstrb, tkeep;
  logic        tlast;
  logic [1:0]  tuser;
  logic        tready;
  logic        bk_start;
  logic [31:0] bk_data;
  logic [3:0]  bk_tstrb, bk_tkeep;
  logic [1:0]  bk_user;
  logic        bk_last;
  logic        nordy, done;
  logic [2:0]  level;
  logic [31:0] beat_cnt;
  logic [15:0] frame_cnt;
  logic        err;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] cap_q[$];

  always #5 clk = ~clk;

  axis_sm_bk_sink #(.DEPTH(4)) dut (
    .axi_sm_aclk    (clk),
    .axi_sm_aresetn (rst_n),
    .axis_sm_tvalid (tvalid),
    .axis_sm_tdata  (tdata),
    .axis_sm_tstrb  (tstrb),
    .axis_sm_tkeep  (tkeep),
    .axis_sm_tlast  (tlast),
    .axis_sm_tuser  (tuser),
    .axis_sm_tready (tready),
    .bk_sm_start    (bk_start),
    .bk_sm_data     (bk_data),
    .bk_sm_tstrb    (bk_tstrb),
    .bk_sm_tkeep    (bk_tkeep),
    .bk_sm_user     (bk_user),
    .bk_sm_last     (bk_last),
    .bk_sm_nordy    (nordy),
    .bk_sm_done     (done),
    .fifo_level     (level),
    .beat_count     (beat_cnt),
    .frame_count    (frame_cnt),
    .err_spurious   (err)
  );

  // Record data of every start pulse, sampled mid-cycle.
  always @(negedge clk) if (bk_start) cap_q.push_back(bk_data);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; tvalid = 1'b0; done = 1'b0; nordy = 1'b0;
    tdata = '0; tstrb = '0; tkeep = '0; tlast = 1'b0; tuser = '0;
    tick; tick;
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l, input logic [1:0] u);
    bit ok;
    ok = 1'b0;
    tdata = d; tstrb = k; tkeep = k; tlast = l; tuser = u; tvalid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (tready) ok = 1'b1;
      tick;
    end
    tvalid = 1'b0;
    n_total++; if (!ok) $display("FAIL send_accept: beat %h not accepted within 200 cycles", d); else n_pass++;
  endtask

  // Give one done per transaction, each in the cycle after its start is observed.
  task automatic serve_dones(input int base, input int n);
    for (int k = 0; k < n; k++) begin
      int t;
      t = 0;
      while (cap_q.size() <= base + k && t < 300) begin tick; t++; end
      if (t >= 300) begin
        n_total++; $display("FAIL serve_wait: start %0d not seen, got %0d starts want %0d", k, cap_q.size() - base, n);
        return;
      end
      done = 1'b1; tick; done = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; tvalid = 1'b0; done = 1'b0; nordy = 1'b0;
    tdata = '0; tstrb = '0; tkeep = '0; tlast = 1'b0; tuser = '0;
    tick; tick;
    n_total++; if (tready !== 1'b0)  $display("FAIL rst_tready: got %b want 0", tready); else n_pass++;
    n_total++; if (bk_start !== 1'b0) $display("FAIL rst_start: got %b want 0", bk_start); else n_pass++;
    n_total++; if ({bk_data, bk_tstrb, bk_tkeep, bk_user, bk_last} !== 43'd0)
      $display("FAIL rst_fields: got %h want 0", {bk_data, bk_tstrb, bk_tkeep, bk_user, bk_last}); else n_pass++;
    n_total++; if ({level, beat_cnt, frame_cnt, err} !== 52'd0)
      $display("FAIL rst_counters: got lvl=%0d beat=%0d frame=%0d err=%b want 0", level, beat_cnt, frame_cnt, err); else n_pass++;
    rst_n = 1'b1;
    n_total++; if (tready !== 1'b0) $display("FAIL rel_tready0: got %b want 0", tready); else n_pass++;
    tick;
    n_total++; if (tready !== 1'b1) $display("FAIL rel_tready1: got %b want 1", tready); else n_pass++;
  endtask

  task automatic test_single;
    int base;
    do_reset;
    base = cap_q.size();
    send(32'hA5A5_0001, 4'hF, 1'b1, 2'd2);
    n_total++; if (bk_start !== 1'b0) $display("FAIL single_early_start: got %b want 0", bk_start); else n_pass++;
    tick;
    n_total++; if (bk_start !== 1'b1) $display("FAIL single_start: got %b want 1", bk_start); else n_pass++;
    n_total++; if (bk_data !== 32'hA5A5_0001) $display("FAIL single_data: got %h want a5a50001", bk_data); else n_pass++;
    n_total++; if ({bk_last, bk_user, bk_tkeep} !== {1'b1, 2'd2, 4'hF})
      $display("FAIL single_side: got %h want %h", {bk_last, bk_user, bk_tkeep}, {1'b1, 2'd2, 4'hF}); else n_pass++;
    tick;
    n_total++; if (bk_start !== 1'b0) $display("FAIL single_pulse_width: got %b want 0", bk_start); else n_pass++;
    tick;
    done = 1'b1; tick; done = 1'b0;
    n_total++; if (beat_cnt !== 32'd1) $display("FAIL single_beat: got %0d want 1", beat_cnt); else n_pass++;
    n_total++; if (frame_cnt !== 16'd1) $display("FAIL single_frame: got %0d want 1", frame_cnt); else n_pass++;
    tick; tick; tick;
    n_total++; if (bk_data !== 32'hA5A5_0001) $display("FAIL single_hold: got %h want a5a50001", bk_data); else n_pass++;
    n_total++; if (cap_q.size() - base !== 1) $display("FAIL single_nstarts: got %0d want 1", cap_q.size() - base); else n_pass++;
    n_total++; if (level !== 3'd0) $display("FAIL single_level: got %0d want 0", level); else n_pass++;
  endtask

  task automatic test_done_in_start;
    do_reset;
    send(32'h0000_BEEF, 4'hF, 1'b0, 2'd0);
    tick;
    done = 1'b1; tick; done = 1'b0;
    n_total++; if (beat_cnt !== 32'd0) $display("FAIL dis_beat: got %0d want 0", beat_cnt); else n_pass++;
    n_total++; if (level !== 3'd1) $display("FAIL dis_level: got %0d want 1", level); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL dis_err: got %b want 0", err); else n_pass++;
    done = 1'b1; tick; done = 1'b0;
    n_total++; if (beat_cnt !== 32'd1) $display("FAIL dis_retire: got %0d want 1", beat_cnt); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int base;
    do_reset;
    base = cap_q.size();
    for (int i = 0; i < 4; i++) send(32'(i), 4'hF, 1'b0, 2'd0);
    n_total++; if (tready !== 1'b0) $display("FAIL b2b_full_tready: got %b want 0", tready); else n_pass++;
    n_total++; if (level !== 3'd4) $display("FAIL b2b_full_level: got %0d want 4", level); else n_pass++;
    fork
      begin send(32'd4, 4'hF, 1'b0, 2'd0); send(32'd5, 4'hF, 1'b1, 2'd0); end
      serve_dones(base, 6);
    join
    tick; tick; tick;
    n_total++; if (cap_q.size() - base !== 6) $display("FAIL b2b_nstarts: got %0d want 6", cap_q.size() - base); else n_pass++;
    for (int i = 0; i < 6 && base + i < cap_q.size(); i++) begin
      n_total++; if (cap_q[base + i] !== 32'(i)) $display("FAIL b2b_order[%0d]: got %h want %h", i, cap_q[base + i], 32'(i)); else n_pass++;
    end
    n_total++; if (beat_cnt !== 32'd6) $display("FAIL b2b_beat: got %0d want 6", beat_cnt); else n_pass++;
    n_total++; if (frame_cnt !== 16'd1) $display("FAIL b2b_frame: got %0d want 1", frame_cnt); else n_pass++;
    n_total++; if (level !== 3'd0) $display("FAIL b2b_level: got %0d want 0", level); else n_pass++;
  endtask

  task automatic test_nordy;
    int base;
    do_reset;
    base = cap_q.size();
    nordy = 1'b1;
    send(32'h10, 4'hF, 1'b0, 2'd0);
    send(32'h11, 4'hF, 1'b0, 2'd0);
    tick; tick; tick;
    n_total++; if (cap_q.size() - base !== 0) $display("FAIL nordy_nostart: got %0d starts want 0", cap_q.size() - base); else n_pass++;
    n_total++; if (level !== 3'd2) $display("FAIL nordy_level: got %0d want 2", level); else n_pass++;
    nordy = 1'b0;
    tick;
    n_total++; if (bk_start !== 1'b1 || bk_data !== 32'h10)
      $display("FAIL nordy_release: got start=%b data=%h want 1/10", bk_start, bk_data); else n_pass++;
    nordy = 1'b1;
    tick;
    done = 1'b1; tick; done = 1'b0;
    n_total++; if (beat_cnt !== 32'd1 || level !== 3'd1)
      $display("FAIL nordy_wait_done: got beat=%0d lvl=%0d want 1/1", beat_cnt, level); else n_pass++;
    tick; tick;
    n_total++; if (cap_q.size() - base !== 1) $display("FAIL nordy_hold2: got %0d starts want 1", cap_q.size() - base); else n_pass++;
    nordy = 1'b0;
    tick;
    n_total++; if (bk_start !== 1'b1 || bk_data !== 32'h11)
      $display("FAIL nordy_second: got start=%b data=%h want 1/11", bk_start, bk_data); else n_pass++;
    tick;
    done = 1'b1; tick; done = 1'b0;
    n_total++; if (beat_cnt !== 32'd2 || level !== 3'd0)
      $display("FAIL nordy_end: got beat=%0d lvl=%0d want 2/0", beat_cnt, level); else n_pass++;
  endtask

  task automatic test_null_beat;
    int base;
    do_reset;
    base = cap_q.size();
    fork
      begin
        send(32'h20, 4'hF, 1'b0, 2'd0);
        send(32'h21, 4'h0, 1'b1, 2'd0);
        send(32'h22, 4'hF, 1'b0, 2'd0);
      end
      serve_dones(base, 2);
    join
    tick; tick; tick; tick;
    n_total++; if (cap_q.size() - base !== 2) $display("FAIL null_nstarts: got %0d want 2", cap_q.size() - base); else n_pass++;
    if (cap_q.size() - base >= 2) begin
      n_total++; if (cap_q[base] !== 32'h20 || cap_q[base + 1] !== 32'h22)
        $display("FAIL null_data: got %h,%h want 20,22", cap_q[base], cap_q[base + 1]); else n_pass++;
    end
    n_total++; if (beat_cnt !== 32'd2) $display("FAIL null_beat: got %0d want 2", beat_cnt); else n_pass++;
    n_total++; if (frame_cnt !== 16'd1) $display("FAIL null_frame: got %0d want 1", frame_cnt); else n_pass++;
    n_total++; if (level !== 3'd0) $display("FAIL null_level: got %0d want 0", level); else n_pass++;
  endtask

  task automatic test_spurious;
    do_reset;
    tick;
    done = 1'b1; tick; done = 1'b0;
    n_total++; if (err !== 1'b1) $display("FAIL spur_set: got %b want 1", err); else n_pass++;
    tick; tick; tick;
    n_total++; if (err !== 1'b1) $display("FAIL spur_sticky: got %b want 1", err); else n_pass++;
    n_total++; if (beat_cnt !== 32'd0 || level !== 3'd0)
      $display("FAIL spur_side: got beat=%0d lvl=%0d want 0/0", beat_cnt, level); else n_pass++;
  endtask

  task automatic test_mid_reset;
    int base;
    do_reset;
    send(32'h31, 4'hF, 1'b0, 2'd1);
    send(32'h32, 4'hF, 1'b0, 2'd1);
    send(32'h33, 4'hF, 1'b0, 2'd1);
    n_total++; if (level !== 3'd3 || bk_data !== 32'h31)
      $display("FAIL mid_pre: got lvl=%0d data=%h want 3/31", level, bk_data); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++; if ({tready, bk_start, bk_data, bk_user, level} !== 38'd0)
      $display("FAIL mid_async: got tready=%b start=%b data=%h user=%0d lvl=%0d want all 0",
               tready, bk_start, bk_data, bk_user, level); else n_pass++;
    tick;
    rst_n = 1'b1;
    tick;
    n_total++; if (tready !== 1'b1) $display("FAIL mid_tready: got %b want 1", tready); else n_pass++;
    base = cap_q.size();
    fork
      send(32'h77, 4'hF, 1'b1, 2'd0);
      serve_dones(base, 1);
    join
    tick;
    n_total++; if (cap_q.size() - base !== 1 || (cap_q.size() > base && cap_q[base] !== 32'h77))
      $display("FAIL mid_deliver: got %0d starts want 1 with data 77", cap_q.size() - base); else n_pass++;
    n_total++; if (beat_cnt !== 32'd1 || frame_cnt !== 16'd1)
      $display("FAIL mid_counts: got beat=%0d frame=%0d want 1/1", beat_cnt, frame_cnt); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_single;
    test_done_in_start;
    test_back_to_back;
    test_nordy;
    test_null_beat;
    test_spurious;
    test_mid_reset;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
